// File: rtl/alu_dispatch_if.sv
// Opcode type shared by the dispatcher, the ALU and the bench, plus the
// fetch-side / completion-side handshake bundle of the dispatcher.
package alu_dispatch_pkg;
    typedef enum logic [4:0] {
        ADD  = 5'd0,
        SUB  = 5'd1,
        MUL  = 5'd2,
        DIV  = 5'd3,
        ABS  = 5'd4,
        SLT  = 5'd5,
        SEQ  = 5'd6,
        SNEZ = 5'd7,
        MIN  = 5'd8,
        SLL  = 5'd9,
        ADDI = 5'd10,
        MULI = 5'd11,
        DIVI = 5'd12,
        SLLI = 5'd13,
        BEQZ = 5'd14,
        JAL  = 5'd15
    } alu_instruction_t;
endpackage

interface alu_dispatch_if #(
    parameter int PC_W = 32,
    parameter int RW   = 5
) ();
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [RW-1:0]   out_rd;
    logic [31:0]     out_data;
    logic            out_we;
    logic            br_taken;
    logic [PC_W-1:0] br_target;
    logic            div_zero;

    // Fetch / consumer side.
    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_rd, out_data, out_we,
               br_taken, br_target, div_zero
    );

    // Dispatcher side.
    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_rd, out_data, out_we,
               br_taken, br_target, div_zero
    );
endinterface

// File: rtl/alu_dispatch.sv
// Single-issue sequencer around a combinational ALU: accept, read operands,
// present them to the ALU for one cycle, write back and report the outcome.
module alu_dispatch
    import alu_dispatch_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int PC_W     = 32,
    localparam int RW      = $clog2(NUM_REGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_dispatch_if.slave    bus,
    output logic [PC_W-1:0]  alu_pc,
    output alu_instruction_t alu_instruction,
    output logic [31:0]      alu_op1,
    output logic [31:0]      alu_op2,
    output logic [31:0]      alu_imm,
    input  logic [31:0]      alu_result,
    input  logic [RW-1:0]    dbg_addr,
    output logic [31:0]      dbg_data
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [31:0]      rf_q [NUM_REGS];

    logic [PC_W-1:0]  alu_pc_q;
    alu_instruction_t alu_instr_q;
    logic [31:0]      alu_op1_q;
    logic [31:0]      alu_op2_q;
    logic [31:0]      alu_imm_q;
    logic [RW-1:0]    rd_q;

    logic [RW-1:0]    out_rd_q;
    logic [31:0]      out_data_q;
    logic             out_we_q;
    logic             br_taken_q;
    logic [PC_W-1:0]  br_target_q;
    logic             div_zero_q;

    logic [31:0]      out_data_d;
    logic             out_we_d;
    logic             br_taken_d;
    logic [PC_W-1:0]  br_target_d;
    logic             div_zero_d;

    logic [4:0]       rd_f, rs1_f, rs2_f;
    logic [RW-1:0]    rs1_idx, rs2_idx;
    logic [31:0]      rs1_val, rs2_val;

    assign rd_f    = bus.in_instr[26:22];
    assign rs1_f   = bus.in_instr[21:17];
    assign rs2_f   = bus.in_instr[16:12];
    assign rs1_idx = rs1_f[RW-1:0];
    assign rs2_idx = rs2_f[RW-1:0];

    // Register file reads: operand ports and debug port, x0 reads as zero.
    always_comb begin
        rs1_val  = (rs1_idx == '0) ? '0 : rf_q[rs1_idx];
        rs2_val  = (rs2_idx == '0) ? '0 : rf_q[rs2_idx];
        dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];
    end

    // Completion record computed from the latched op and the ALU result.
    always_comb begin
        out_data_d  = '0;
        out_we_d    = 1'b0;
        br_taken_d  = 1'b0;
        br_target_d = alu_pc_q + PC_W'(1);
        div_zero_d  = 1'b0;
        case (alu_instr_q)
            ADD, SUB, MUL, ABS, SLT, SEQ, SNEZ, MIN, SLL,
            ADDI, MULI, SLLI: begin
                out_data_d = alu_result;
                out_we_d   = 1'b1;
            end
            DIV: begin
                out_we_d   = 1'b1;
                div_zero_d = (alu_op2_q == '0);
                out_data_d = div_zero_d ? '1 : alu_result;
            end
            DIVI: begin
                out_we_d   = 1'b1;
                div_zero_d = (alu_imm_q == '0);
                out_data_d = div_zero_d ? '1 : alu_result;
            end
            JAL: begin
                out_data_d  = 32'(alu_pc_q + PC_W'(1));
                out_we_d    = 1'b1;
                br_taken_d  = 1'b1;
                br_target_d = alu_result[PC_W-1:0];
            end
            BEQZ: begin
                br_taken_d = (alu_result == 32'd1);
                if (br_taken_d) begin
                    br_target_d = alu_pc_q + PC_W'($signed(alu_imm_q));
                end
            end
            default: ;
        endcase
        if (rd_q == '0) begin
            out_we_d = 1'b0;
        end
    end

    // Sequencer: IDLE accepts, EXEC drives the ALU and writes back, DONE holds the record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            alu_pc_q    <= '0;
            alu_instr_q <= ADD;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            alu_imm_q   <= '0;
            rd_q        <= '0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_we_q    <= 1'b0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            div_zero_q  <= 1'b0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        state_q     <= S_EXEC;
                        in_ready_q  <= 1'b0;
                        alu_pc_q    <= bus.in_pc;
                        alu_instr_q <= alu_instruction_t'(bus.in_instr[31:27]);
                        alu_op1_q   <= rs1_val;
                        alu_op2_q   <= rs2_val;
                        alu_imm_q   <= {{20{bus.in_instr[11]}}, bus.in_instr[11:0]};
                        rd_q        <= rd_f[RW-1:0];
                    end
                end
                S_EXEC: begin
                    state_q     <= S_DONE;
                    out_valid_q <= 1'b1;
                    out_rd_q    <= rd_q;
                    out_data_q  <= out_data_d;
                    out_we_q    <= out_we_d;
                    br_taken_q  <= br_taken_d;
                    br_target_q <= br_target_d;
                    div_zero_q  <= div_zero_d;
                    if (out_we_d) begin
                        rf_q[rd_q] <= out_data_d;
                    end
                    alu_pc_q    <= '0;
                    alu_instr_q <= ADD;
                    alu_op1_q   <= '0;
                    alu_op2_q   <= '0;
                    alu_imm_q   <= '0;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        out_rd_q    <= '0;
                        out_data_q  <= '0;
                        out_we_q    <= 1'b0;
                        br_taken_q  <= 1'b0;
                        br_target_q <= '0;
                        div_zero_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_we     = out_we_q;
    assign bus.br_taken   = br_taken_q;
    assign bus.br_target  = br_target_q;
    assign bus.div_zero   = div_zero_q;
    assign alu_pc         = alu_pc_q;
    assign alu_instruction = alu_instr_q;
    assign alu_op1        = alu_op1_q;
    assign alu_op2        = alu_op2_q;
    assign alu_imm        = alu_imm_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed plus random bench for alu_dispatch with a behavioural ALU and
// a reference register-file model.
module tb_alu_dispatch;
    import alu_dispatch_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [31:0]      alu_pc;
    alu_instruction_t alu_instruction;
    logic [31:0]      alu_op1, alu_op2, alu_imm, alu_result;
    logic [4:0]       dbg_addr;
    logic [31:0]      dbg_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rf [32];

    alu_dispatch_if #(.PC_W(32), .RW(5)) bus_if ();

    alu_dispatch #(.NUM_REGS(32), .PC_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .bus             (bus_if),
        .alu_pc          (alu_pc),
        .alu_instruction (alu_instruction),
        .alu_op1         (alu_op1),
        .alu_op2         (alu_op2),
        .alu_imm         (alu_imm),
        .alu_result      (alu_result),
        .dbg_addr        (dbg_addr),
        .dbg_data        (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU; divide by zero and unknown ops return junk the dispatcher must ignore.
    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a, b, imm, pc);
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a * b;
            5'd3:  return (b == 0) ? 32'h0BAD_0BAD : a / b;
            5'd4:  return ($signed(a) < 0) ? -a : a;
            5'd5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd6:  return (a == b) ? 32'd1 : 32'd0;
            5'd7:  return (a != 0) ? 32'd1 : 32'd0;
            5'd8:  return (a < b) ? a : b;
            5'd9:  return a << b[4:0];
            5'd10: return a + imm;
            5'd11: return a * imm;
            5'd12: return (imm == 0) ? 32'h0BAD_0BAD : a / imm;
            5'd13: return a << imm[4:0];
            5'd14: return (a == 0) ? 32'd1 : 32'd0;
            5'd15: return pc + imm;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always_comb alu_result = alu_fn(alu_instruction, alu_op1, alu_op2, alu_imm, alu_pc);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one op, follow it through to completion and compare against the model.
    task automatic do_op(input logic [4:0] op, input int rd, input int rs1, input int rs2,
                         input logic [11:0] imm, input logic [31:0] pc, input int hold);
        logic [31:0] a, b, immx, res, e_data, e_tgt, held;
        logic e_we, e_taken, e_dz, data_known;
        int lat;
        a    = (rs1 == 0) ? 32'd0 : model_rf[rs1];
        b    = (rs2 == 0) ? 32'd0 : model_rf[rs2];
        immx = {{20{imm[11]}}, imm};
        res  = alu_fn(op, a, b, immx, pc);
        e_data = 0; e_we = 0; e_taken = 0; e_tgt = pc + 1; e_dz = 0; data_known = 1;
        if ((op == DIV && b == 0) || (op == DIVI && immx == 0)) begin
            e_data = 32'hFFFF_FFFF; e_dz = 1; e_we = 1;
        end else if (op <= 5'd13) begin
            e_data = res; e_we = 1;
        end else if (op == JAL) begin
            e_data = pc + 1; e_we = 1; e_taken = 1; e_tgt = res;
        end else if (op == BEQZ) begin
            e_taken = (a == 0);
            if (e_taken) e_tgt = pc + immx;
            data_known = 0;
        end
        if (rd == 0) begin
            e_we = 0; data_known = 0;
        end

        @(negedge clk);
        check("in_ready_idle", {31'd0, bus_if.in_ready}, 32'd1);
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = {op, 5'(rd), 5'(rs1), 5'(rs2), imm};
        bus_if.in_pc    = pc;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        check("exec_alu_pc", alu_pc, pc);
        check("exec_alu_instr", 32'(alu_instruction), 32'(op));
        check("exec_alu_op1", alu_op1, a);
        check("exec_alu_op2", alu_op2, b);
        check("exec_alu_imm", alu_imm, immx);
        lat = 1;
        while (!bus_if.out_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd2);
        check("done_alu_op1_zero", alu_op1, 32'd0);
        check("out_rd", 32'(bus_if.out_rd), 32'(rd));
        if (data_known) check("out_data", bus_if.out_data, e_data);
        check("out_we", {31'd0, bus_if.out_we}, {31'd0, e_we});
        check("br_taken", {31'd0, bus_if.br_taken}, {31'd0, e_taken});
        check("br_target", bus_if.br_target, e_tgt);
        check("div_zero", {31'd0, bus_if.div_zero}, {31'd0, e_dz});
        held = bus_if.out_data;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
            check("hold_out_data", bus_if.out_data, held);
            check("hold_in_ready", {31'd0, bus_if.in_ready}, 32'd0);
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_if.out_ready = 1'b0;
        check("post_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("post_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        if (e_we) model_rf[rd] = e_data;
        dbg_addr = 5'(rd);
        #1;
        check("dbg_rd", dbg_data, (rd == 0) ? 32'd0 : model_rf[rd]);
    endtask

    initial begin
        logic [4:0]  r_op;
        logic [11:0] r_imm;
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
        rst_n = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_instr  = 32'd0;
        bus_if.in_pc     = 32'd0;
        bus_if.out_ready = 1'b0;
        dbg_addr = 5'd0;
        #12;
        check("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        check("rst_out_data", bus_if.out_data, 32'd0);
        check("rst_br_target", bus_if.br_target, 32'd0);
        check("rst_alu_op1", alu_op1, 32'd0);
        check("rst_alu_pc", alu_pc, 32'd0);
        rst_n = 1'b1;

        do_op(ADDI, 1, 0, 0, 12'd5, 32'h0, 0);
        do_op(ADD,  2, 1, 1, 12'd0, 32'h1, 0);
        do_op(SUB,  3, 0, 1, 12'd0, 32'h2, 0);
        check("x3_neg5", model_rf[3], 32'hFFFF_FFFB);
        do_op(ABS,  4, 3, 0, 12'd0, 32'h3, 0);
        do_op(MIN,  5, 1, 3, 12'd0, 32'h4, 0);
        do_op(DIV,  6, 1, 0, 12'd0, 32'h5, 0);
        do_op(DIVI, 6, 1, 0, 12'd0, 32'h6, 0);
        do_op(DIVI, 6, 1, 0, 12'd2, 32'h7, 0);
        do_op(BEQZ, 0, 0, 0, 12'hFFC, 32'h10, 0);
        do_op(BEQZ, 0, 1, 0, 12'hFFC, 32'h10, 0);
        do_op(JAL,  7, 0, 0, 12'd8, 32'h20, 0);
        do_op(ADDI, 0, 0, 0, 12'd9, 32'h21, 0);
        do_op(5'd20, 9, 1, 2, 12'd3, 32'h22, 0);
        do_op(ADD,  10, 2, 4, 12'd0, 32'h23, 5);

        // Reset during EXEC: op is dropped and every register returns to zero.
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.in_instr = {ADDI, 5'd8, 5'd1, 5'd0, 12'd77};
        bus_if.in_pc    = 32'h40;
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("midrst_alu_op1", alu_op1, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        dbg_addr = 5'd8; #1;
        check("midrst_x8", dbg_data, 32'd0);
        dbg_addr = 5'd1; #1;
        check("midrst_x1", dbg_data, 32'd0);
        for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;

        for (int n = 0; n < 60; n++) begin
            r_op  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(16, 31)) : 5'($urandom_range(0, 15));
            r_imm = ($urandom_range(0, 4) == 0) ? 12'd0 : 12'($urandom);
            do_op(r_op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), r_imm, $urandom, int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL timeout observed=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
